// File: rtl/sprite_line_fetcher_pkg.sv
// Shared attribute-field layout, sprite geometry and scan FSM encoding for the sprite line fetcher.
package sprite_line_fetcher_pkg;

  localparam int SPRITE_DIM  = 16;
  localparam int SPRITE_ID_W = 6;

  localparam int ATTR_EN    = 31;
  localparam int ATTR_HFLIP = 30;
  localparam int ATTR_ID_HI = 29;
  localparam int ATTR_ID_LO = 24;
  localparam int ATTR_Y_HI  = 19;
  localparam int ATTR_Y_LO  = 10;
  localparam int ATTR_X_HI  = 9;
  localparam int ATTR_X_LO  = 0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ATTR  = 3'd1,
    S_EVAL  = 3'd2,
    S_FETCH = 3'd3,
    S_FLUSH = 3'd4
  } state_t;

endpackage

// File: rtl/sprite_line_buffer.sv
// Double-banked 1bpp line buffer: set-only writes into the back bank, read-clear of the front bank.
// bank_sel names the back bank; the front bank is the other one, so the two ports never collide.
module sprite_line_buffer #(
  parameter int H_RES = 640
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bank_sel,
  input  logic        wr_en,
  input  logic [10:0] wr_addr,
  input  logic        rd_en,
  input  logic [9:0]  rd_addr,
  output logic        rd_bit
);

  logic mem0 [H_RES];
  logic mem1 [H_RES];
  logic wr_ok;
  logic rd_ok;

  // Sprites overhanging the right edge are clipped here, never wrapped.
  assign wr_ok = wr_en && (wr_addr < 11'(H_RES));
  assign rd_ok = rd_en && (rd_addr < 10'(H_RES));

  always_ff @(posedge clk) begin
    if (wr_ok && !bank_sel) mem0[wr_addr[9:0]] <= 1'b1;
    if (rd_ok && bank_sel)  mem0[rd_addr]      <= 1'b0;
    if (wr_ok && bank_sel)  mem1[wr_addr[9:0]] <= 1'b1;
    if (rd_ok && !bank_sel) mem1[rd_addr]      <= 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      rd_bit <= 1'b0;
    else if (rd_ok) rd_bit <= bank_sel ? mem0[rd_addr] : mem1[rd_addr];
    else            rd_bit <= 1'b0;
  end

endmodule

// File: rtl/sprite_line_fetcher.sv
// Scans the attribute table for line N+1 during line N and ORs pattern bits into the back line buffer.
// SPRITE_HFLIP_EN enables horizontal flip from attribute bit 30.
module sprite_line_fetcher
  import sprite_line_fetcher_pkg::*;
#(
  parameter int NUM_SPRITES  = 64,
  parameter int MAX_PER_LINE = 8,
  parameter int H_RES        = 640
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        line_start,
  input  logic [9:0]  line_y,
  output logic [5:0]  attr_addr,
  input  logic [31:0] attr_data,
  output logic        spr_ren,
  output logic [13:0] spr_raddr,
  input  logic        spr_rdata,
  input  logic        pix_valid,
  input  logic [9:0]  pix_x,
  output logic        pix_on,
  output logic        busy,
  output logic        overflow
);

  localparam int HW = $clog2(MAX_PER_LINE + 1);

  state_t                 state;
  logic [5:0]             idx;
  logic [9:0]             ly;
  logic [HW-1:0]          hits;
  logic [3:0]             col;
  logic [3:0]             row_q;
  logic [SPRITE_ID_W-1:0] id_q;
  logic [9:0]             x_q;
  logic                   bank_sel;
  logic                   wr_en;
  logic [10:0]            wr_addr;

  logic [9:0]             a_y;
  logic [9:0]             row_full;
  logic                   hit;
  logic                   take;
  logic                   adv;
  logic [3:0]             col_nxt;
  logic [3:0]             pcol_first;
  logic [3:0]             pcol_nxt;

  assign attr_addr = idx;
  assign a_y       = attr_data[ATTR_Y_HI:ATTR_Y_LO];
  assign row_full  = ly - a_y;
  assign hit       = attr_data[ATTR_EN] && (row_full[9:4] == 6'd0);
  assign take      = hit && (hits < HW'(MAX_PER_LINE));
  assign adv       = ((state == S_EVAL) && !take) || (state == S_FLUSH);
  assign col_nxt   = col + 4'd1;

`ifdef SPRITE_HFLIP_EN
  logic hflip_q;
  wire  attr_unused = ^attr_data[23:20];
  assign pcol_first = attr_data[ATTR_HFLIP] ? 4'hF : 4'h0;
  assign pcol_nxt   = hflip_q ? ~col_nxt : col_nxt;
`else
  wire  attr_unused = ^{attr_data[ATTR_HFLIP], attr_data[23:20]};
  assign pcol_first = 4'h0;
  assign pcol_nxt   = col_nxt;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      ly        <= '0;
      hits      <= '0;
      col       <= '0;
      row_q     <= '0;
      id_q      <= '0;
      x_q       <= '0;
      bank_sel  <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      spr_ren   <= 1'b0;
      spr_raddr <= '0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
`ifdef SPRITE_HFLIP_EN
      hflip_q   <= 1'b0;
`endif
    end else begin
      // A read issued in the cycle of a line_start would land in the freshly swapped bank.
      wr_en   <= spr_ren && !line_start;
      wr_addr <= {1'b0, x_q} + {7'd0, col};
      if (line_start) begin
        bank_sel <= ~bank_sel;
        hits     <= '0;
        overflow <= 1'b0;
        idx      <= '0;
        ly       <= line_y;
        spr_ren  <= 1'b0;
        busy     <= 1'b1;
        state    <= S_ATTR;
      end else begin
        case (state)
          S_ATTR: state <= S_EVAL;
          S_EVAL: begin
            if (take) begin
              hits      <= hits + HW'(1);
              id_q      <= attr_data[ATTR_ID_HI:ATTR_ID_LO];
              row_q     <= row_full[3:0];
              x_q       <= attr_data[ATTR_X_HI:ATTR_X_LO];
              col       <= 4'd0;
              spr_ren   <= 1'b1;
              spr_raddr <= {attr_data[ATTR_ID_HI:ATTR_ID_LO], row_full[3:0], pcol_first};
`ifdef SPRITE_HFLIP_EN
              hflip_q   <= attr_data[ATTR_HFLIP];
`endif
              state     <= S_FETCH;
            end else if (hit) begin
              overflow <= 1'b1;
            end
          end
          S_FETCH: begin
            if (col == 4'(SPRITE_DIM - 1)) begin
              spr_ren <= 1'b0;
              state   <= S_FLUSH;
            end else begin
              col       <= col_nxt;
              spr_raddr <= {id_q, row_q, pcol_nxt};
            end
          end
          default: ;
        endcase
        if (adv) begin
          if (idx == 6'(NUM_SPRITES - 1)) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            idx   <= idx + 6'd1;
            state <= S_ATTR;
          end
        end
      end
    end
  end

  sprite_line_buffer #(.H_RES(H_RES)) u_buf (
    .clk      (clk),
    .reset    (reset),
    .bank_sel (bank_sel),
    .wr_en    (wr_en && spr_rdata),
    .wr_addr  (wr_addr),
    .rd_en    (pix_valid),
    .rd_addr  (pix_x),
    .rd_bit   (pix_on)
  );

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// Directed bench: attribute/pattern memory models, per-line scan and full display sweeps.
module tb_sprite_line_fetcher;

  localparam int H_RES = 640;

  logic        clk;
  logic        reset;
  logic        line_start;
  logic [9:0]  line_y;
  logic [5:0]  attr_addr;
  logic [31:0] attr_data;
  logic        spr_ren;
  logic [13:0] spr_raddr;
  logic        spr_rdata;
  logic        pix_valid;
  logic [9:0]  pix_x;
  logic        pix_on;
  logic        busy;
  logic        overflow;

  logic [31:0] attr_mem [64];
  logic        pat [16384];
  logic        exp_pix [1024];
  logic [13:0] rd_log [$];
  int          rd_total;
  int          n_cmp;
  int          n_err;
  int          base;

  sprite_line_fetcher #(.NUM_SPRITES(64), .MAX_PER_LINE(8), .H_RES(H_RES)) dut (
    .clk        (clk),
    .reset      (reset),
    .line_start (line_start),
    .line_y     (line_y),
    .attr_addr  (attr_addr),
    .attr_data  (attr_data),
    .spr_ren    (spr_ren),
    .spr_raddr  (spr_raddr),
    .spr_rdata  (spr_rdata),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .pix_on     (pix_on),
    .busy       (busy),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    attr_data <= attr_mem[attr_addr];
    spr_rdata <= spr_ren ? pat[spr_raddr] : 1'b0;
    if (!reset && spr_ren) begin
      rd_log.push_back(spr_raddr);
      rd_total++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_attr(input logic en, input logic hf, input logic [5:0] id,
                                          input logic [9:0] y, input logic [9:0] x);
    return {en, hf, id, 4'd0, y, x};
  endfunction

  task automatic set_row(input logic [5:0] id, input logic [3:0] row, input logic [15:0] val);
    for (int c = 0; c < 16; c++) pat[{id, row, 4'(c)}] = val[15-c];
  endtask

  task automatic clear_table();
    for (int i = 0; i < 64; i++) attr_mem[i] = 32'd0;
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 1024; i++) exp_pix[i] = 1'b0;
  endtask

  task automatic start_line(input logic [9:0] y);
    line_y     = y;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000 && busy; i++) tick();
    chk("scan_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic sweep(input bit check, input string tag);
    for (int x = 0; x < H_RES + 4; x++) begin
      pix_x     = 10'(x);
      pix_valid = 1'b1;
      tick();
      pix_valid = 1'b0;
      if (check) chk($sformatf("%s_x%0d", tag, x), {31'd0, pix_on}, {31'd0, exp_pix[x]});
    end
  endtask

  // Next line: empty table, overflow must clear, then display and check the prepared line.
  task automatic show(input string tag);
    clear_table();
    start_line(10'd900);
    chk({tag, "_ovf_clr"}, {31'd0, overflow}, 32'd0);
    sweep(1'b1, tag);
    wait_idle();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_cmp = 0; n_err = 0; rd_total = 0;
    line_start = 1'b0; line_y = '0; pix_valid = 1'b0; pix_x = '0;
    clear_table();
    for (int i = 0; i < 16384; i++) pat[i] = 1'b0;
    clear_exp();

    reset = 1'b1;
    repeat (3) tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_ren", {31'd0, spr_ren}, 32'd0);
    chk("rst_pix", {31'd0, pix_on}, 32'd0);
    chk("rst_attr", {26'd0, attr_addr}, 32'd0);
    reset = 1'b0;
    tick();

    for (int k = 0; k < 2; k++) begin
      start_line(10'd900);
      wait_idle();
      sweep(1'b0, "init");
    end

    // Basic hit: row 5 of sprite id 3, bits at cols 0 and 15.
    attr_mem[0] = mk_attr(1, 0, 6'd3, 10'd100, 10'd10);
    set_row(6'd3, 4'd5, 16'h8001);
    base = rd_total;
    start_line(10'd105);
    wait_idle();
    chk("t1_reads", rd_total - base, 16);
    chk("t1_first", {18'd0, rd_log[base]}, 32'h350);
    chk("t1_last", {18'd0, rd_log[base+15]}, 32'h35F);
    chk("t1_ovf", {31'd0, overflow}, 32'd0);
    clear_exp(); exp_pix[10] = 1; exp_pix[25] = 1;
    show("t1");

    // Overlap ORs; zero bits do not clear; disabled entry issues no reads.
    attr_mem[0] = mk_attr(1, 0, 6'd1, 10'd50, 10'd0);
    attr_mem[1] = mk_attr(0, 0, 6'd2, 10'd50, 10'd40);
    attr_mem[2] = mk_attr(1, 0, 6'd7, 10'd50, 10'd8);
    set_row(6'd1, 4'd0, 16'h00FF);
    set_row(6'd2, 4'd0, 16'hFFFF);
    set_row(6'd7, 4'd0, 16'h0F0F);
    base = rd_total;
    start_line(10'd50);
    wait_idle();
    chk("t2_reads", rd_total - base, 32);
    clear_exp();
    for (int i = 8; i < 16; i++) exp_pix[i] = 1;
    for (int i = 20; i < 24; i++) exp_pix[i] = 1;
    show("t2");

    // Right-edge clipping without wrap.
    attr_mem[0] = mk_attr(1, 0, 6'd8, 10'd10, 10'd630);
    set_row(6'd8, 4'd2, 16'hFFFF);
    base = rd_total;
    start_line(10'd12);
    wait_idle();
    chk("t3_reads", rd_total - base, 16);
    clear_exp();
    for (int i = 630; i < 640; i++) exp_pix[i] = 1;
    show("t3");

    // Ten hits on one line: only the first eight drawn.
    for (int k = 0; k < 10; k++) attr_mem[k] = mk_attr(1, 0, 6'd4, 10'd200, 10'(20 * k));
    set_row(6'd4, 4'd0, 16'h8000);
    base = rd_total;
    start_line(10'd200);
    wait_idle();
    chk("t4_reads", rd_total - base, 128);
    chk("t4_ovf", {31'd0, overflow}, 32'd1);
    clear_exp();
    for (int k = 0; k < 8; k++) exp_pix[20 * k] = 1;
    show("t4");

    // Horizontal flip moves col-0 bit to the far edge only with the feature built in.
    attr_mem[0] = mk_attr(1, 1, 6'd9, 10'd0, 10'd20);
    set_row(6'd9, 4'd3, 16'h8000);
    start_line(10'd3);
    wait_idle();
    clear_exp();
`ifdef SPRITE_HFLIP_EN
    exp_pix[35] = 1;
`else
    exp_pix[20] = 1;
`endif
    show("t6");

    // Abort mid-fetch: the read issued in the abort cycle must not reach the new bank.
    attr_mem[0] = mk_attr(1, 0, 6'd5, 10'd300, 10'd100);
    set_row(6'd5, 4'd0, 16'hFFFF);
    base = rd_total;
    start_line(10'd300);
    for (int i = 0; i < 200 && (rd_total - base) < 5; i++) tick();
    chk("t5_reach", {31'd0, spr_ren}, 32'd1);
    line_y     = 10'd700;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    chk("t5_busy", {31'd0, busy}, 32'd1);
    chk("t5_idx", {26'd0, attr_addr}, 32'd0);
    chk("t5_ren", {31'd0, spr_ren}, 32'd0);
    sweep(1'b0, "t5_partial");
    wait_idle();
    clear_exp();
    show("t5");

    // Reset in the middle of a scan.
    attr_mem[0] = mk_attr(1, 0, 6'd5, 10'd300, 10'd100);
    base = rd_total;
    start_line(10'd300);
    for (int i = 0; i < 200 && (rd_total - base) < 3; i++) tick();
    chk("t5r_reach", {31'd0, spr_ren}, 32'd1);
    reset = 1'b1;
    #1;
    chk("t5r_busy", {31'd0, busy}, 32'd0);
    chk("t5r_ren", {31'd0, spr_ren}, 32'd0);
    chk("t5r_ovf", {31'd0, overflow}, 32'd0);
    chk("t5r_idx", {26'd0, attr_addr}, 32'd0);
    chk("t5r_pix", {31'd0, pix_on}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("t5r_idle", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
